// File: rtl/traceback_ctrl.sv
// traceback_ctrl: survivor-memory bank sequencer with concurrent training and decode traceback pointers
module traceback_ctrl #(
  parameter int ADDR_W  = 5,
  parameter int STATE_W = 6
) (
  input  logic                    clk,
  input  logic                    RSTn,
  input  logic                    flush,
  input  logic                    d_in_valid,
  input  logic [2**STATE_W-1:0]   selection,
  input  logic [STATE_W-1:0]      best_state,
  output logic [1:0]              mem_bank,
  output logic [3:0]              wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [2**STATE_W-1:0]   wr_data,
  output logic [ADDR_W-1:0]       rd_addr,
  input  logic [2**STATE_W-1:0]   d_o_mem_A,
  input  logic [2**STATE_W-1:0]   d_o_mem_B,
  input  logic [2**STATE_W-1:0]   d_o_mem_C,
  input  logic [2**STATE_W-1:0]   d_o_mem_D,
  output logic [2**ADDR_W-1:0]    dec_word,
  output logic                    dec_valid
);
  localparam int N = 2**STATE_W;
  localparam int L = 2**ADDR_W;
  typedef struct packed {
    logic [1:0]         w;
    logic [ADDR_W-1:0]  wa;
    logic [1:0]         fill;
    logic [STATE_W-1:0] bs;
    logic               rv;
    logic [ADDR_W-1:0]  a;
    logic [1:0]         wq;
    logic               tr_on;
    logic               dc_on;
    logic [STATE_W-1:0] tr;
    logic [STATE_W-1:0] dc;
    logic [L-1:0]       acc;
    logic [ADDR_W-1:0]  cnt;
    logic               done;
    logic [L-1:0]       word;
    logic               vld;
  } st_t;
  st_t q, d;
  logic [N-1:0] bank [4];
  logic [1:0] tr_b, dc_b;
  logic first, tr_step, dc_step;
  logic [STATE_W-1:0] tr_cur, dc_cur;
  assign bank[0] = d_o_mem_A;
  assign bank[1] = d_o_mem_B;
  assign bank[2] = d_o_mem_C;
  assign bank[3] = d_o_mem_D;
  // bank, address and enables are captured at issue time so the step one cycle later uses the matching read data
  assign tr_b = q.wq - 2'd1;
  assign dc_b = q.wq + 2'd1;
  assign first = &q.a;
  assign tr_cur = first ? q.bs : q.tr;
  assign dc_cur = first ? q.tr : q.dc;
  assign tr_step = q.rv & q.tr_on;
  assign dc_step = q.rv & q.dc_on;
  always_comb begin
    d = q;
    d.rv = d_in_valid;
    d.done = dc_step & ~|q.a & &q.cnt;
    d.vld = q.done;
    if (q.done) d.word = q.acc;
    if (d_in_valid) begin
      d.wa = q.wa + 1'b1;
      d.a = ~q.wa;
      d.wq = q.w;
      d.tr_on = |q.fill;
      d.dc_on = &q.fill;
      if (&q.wa) begin
        d.w = q.w + 2'd1;
        d.bs = best_state;
        d.fill = q.fill + {1'b0, ~&q.fill};
      end
    end
    if (tr_step) d.tr = {tr_cur[STATE_W-2:0], bank[tr_b][tr_cur]};
    if (dc_step) begin
      d.dc = {dc_cur[STATE_W-2:0], bank[dc_b][dc_cur]};
      d.acc[q.a] = dc_cur[STATE_W-1];
      d.cnt = first ? ADDR_W'(1) : q.cnt + 1'b1;
    end
    if (flush) d = '0;
  end
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) q <= '0;
    else q <= d;
  end
  assign mem_bank = q.w;
  assign wr_addr = q.wa;
  assign rd_addr = ~q.wa;
  assign wr_data = selection;
  assign wr_en = (RSTn & d_in_valid & ~flush) ? 4'b1 << q.w : 4'b0;
  assign dec_word = q.word;
  assign dec_valid = q.vld;
endmodule

// File: tb/tb_traceback_ctrl.sv
// tb_traceback_ctrl: bank-memory environment plus a source-bit reference for the traceback controller
module tb_traceback_ctrl;
  logic clk = 1'b0;
  logic RSTn, flush, d_in_valid, dec_valid;
  logic [63:0] selection, wr_data, d_o_mem_A, d_o_mem_B, d_o_mem_C, d_o_mem_D;
  logic [5:0] best_state;
  logic [1:0] mem_bank;
  logic [3:0] wr_en;
  logic [4:0] wr_addr, rd_addr;
  logic [31:0] dec_word;
  logic [63:0] mem [4][32];
  int n_vec = 0, n_err = 0, widx = 0, pulses = 0, seg_tick = 0, mode = 0;
  bit cont = 1'b0;
  logic [5:0] s = 6'd0;
  logic [31:0] cur_blk = 32'd0;
  logic [31:0] blk_q [$];

  traceback_ctrl dut (
    .clk(clk), .RSTn(RSTn), .flush(flush), .d_in_valid(d_in_valid),
    .selection(selection), .best_state(best_state), .mem_bank(mem_bank),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
    .d_o_mem_A(d_o_mem_A), .d_o_mem_B(d_o_mem_B), .d_o_mem_C(d_o_mem_C), .d_o_mem_D(d_o_mem_D),
    .dec_word(dec_word), .dec_valid(dec_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) if (wr_en[b]) mem[b][wr_addr] <= wr_data;
    d_o_mem_A <= mem[0][rd_addr];
    d_o_mem_B <= mem[1][rd_addr];
    d_o_mem_C <= mem[2][rd_addr];
    d_o_mem_D <= mem[3][rd_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock: encoder advances a true trellis path; its survivor bit is planted in a random selection word
  task automatic tick(input bit v, input bit fl);
    logic u;
    logic [63:0] sel;
    logic [5:0] sn;
    logic [1:0] b;
    u = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
    sn = {u, s[5:1]};
    sel = (mode == 1) ? 64'd0 : (mode == 2) ? '1 : {$urandom, $urandom};
    sel[sn] = s[0];
    selection = sel;
    best_state = sn;
    d_in_valid = v;
    flush = fl;
    #1;
    if (!fl) begin
      b = 2'((widx / 32) % 4);
      chk("wr_addr", 64'(wr_addr), 64'(widx % 32));
      chk("rd_addr", 64'(rd_addr), 64'(31 - widx % 32));
      chk("mem_bank", 64'(mem_bank), 64'(b));
      chk("wr_en", 64'(wr_en), v ? 64'(4'b1 << b) : 64'd0);
      if (v) chk("wr_data", wr_data, sel);
    end
    @(posedge clk);
    #1;
    if (fl) begin
      widx = 0;
      pulses = 0;
      seg_tick = 0;
      blk_q.delete();
      chk("flush_dec_valid", 64'(dec_valid), 64'd0);
    end else begin
      if (v) begin
        s = sn;
        cur_blk[widx % 32] = u;
        widx++;
        if (widx % 32 == 0) blk_q.push_back(cur_blk);
      end
      if (dec_valid) begin
        chk("dec_pending", 64'(blk_q.size() > 0), 64'd1);
        if (blk_q.size() > 0) chk("dec_word", 64'(dec_word), 64'(blk_q.pop_front()));
        if (cont) chk("dec_latency", 64'(seg_tick), 64'(129 + 32 * pulses));
        pulses++;
      end
      seg_tick++;
    end
  endtask

  task automatic seg_done(input string tag);
    chk(tag, 64'(pulses), 64'((widx / 32 > 3) ? widx / 32 - 3 : 0));
  endtask

  initial begin
    RSTn = 1'b0;
    flush = 1'b0;
    d_in_valid = 1'b1;
    selection = '1;
    best_state = 6'h3F;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_bank", 64'(mem_bank), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr), 64'd31);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_dec_valid", 64'(dec_valid), 64'd0);
    chk("rst_dec_word", 64'(dec_word), 64'd0);
    d_in_valid = 1'b0;
    RSTn = 1'b1;
    repeat (40) tick(1'b1, 1'b0);
    chk("t2_bank", 64'(mem_bank), 64'd1);
    chk("t2_wr_addr", 64'(wr_addr), 64'd8);
    repeat (4) tick(1'b1, 1'b0);
    repeat (5) tick(1'b0, 1'b0);
    chk("t3_wr_addr", 64'(wr_addr), 64'd12);
    chk("t3_rd_addr", 64'(rd_addr), 64'd19);
    repeat (20) tick(1'b1, 1'b0);
    seg_done("t3_pulses");
    mode = 1;
    s = 6'd0;
    cont = 1'b1;
    tick(1'b1, 1'b1);
    repeat (160) tick(1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b0);
    chk("t4_pulses", 64'(pulses), 64'd2);
    mode = 2;
    s = 6'h3F;
    tick(1'b0, 1'b1);
    repeat (160) tick(1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b0);
    chk("t5_pulses", 64'(pulses), 64'd2);
    mode = 0;
    cont = 1'b0;
    tick(1'b0, 1'b1);
    for (int i = 0; i < 4000 && widx < 500; i++) tick($urandom_range(0, 3) != 0, 1'b0);
    chk("t6_words_a", 64'(widx), 64'd500);
    seg_done("t6_pulses_a");
    tick(1'b1, 1'b1);
    for (int i = 0; i < 4000 && widx < 524; i++) tick($urandom_range(0, 3) != 0, 1'b0);
    chk("t6_words_b", 64'(widx), 64'd524);
    repeat (4) tick(1'b0, 1'b0);
    seg_done("t6_pulses_b");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
